// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the GPU command dispatcher: control opcodes,
// MODE/SELECT field positions and the control address.
package gpu_cmd_pkg;

    localparam logic [3:0] OP_START_RASTER = 4'd0;
    localparam logic [3:0] OP_START_WRITE  = 4'd2;
    localparam logic [3:0] OP_WAIT_FLUSH   = 4'd4;
    localparam logic [3:0] OP_CLEAR        = 4'd5;
    localparam logic [3:0] OP_SELECT       = 4'd6;
    localparam logic [3:0] OP_FENCE        = 4'd7;
    localparam logic [3:0] OP_MODE         = 4'd8;

    localparam int CTRL_ADDR      = 0;
    localparam int MODE_AUTO_BIT  = 4;
    localparam int MODE_BCAST_BIT = 5;
    localparam int SEL_LSB        = 8;
    localparam int SEL_MSB        = 15;

endpackage

// File: rtl/gpu_cmd_dispatch_fifo.sv
// Single-clock FIFO holding (addr, data) command words; head read straight
// from the storage registers, occupancy exported as a count.
module sync_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == CW'(0));

endmodule

// File: rtl/gpu_cmd_dispatch.sv
// Command front end: buffers command words, decodes control opcodes and
// issues register writes and start/clear strobes to NUM_UNITS renderers.
module gpu_cmd_dispatch
    import gpu_cmd_pkg::*;
#(
    parameter int NUM_UNITS  = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 32,
    parameter int CMD_ADDR_W = 4
) (
    input  logic                          gpu_clk,
    input  logic                          gpu_rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CMD_ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic [NUM_UNITS-1:0]          reg_we,
    output logic [CMD_ADDR_W-1:0]         reg_addr,
    output logic [DATA_W-1:0]             reg_data,
    output logic [NUM_UNITS-1:0]          unit_start,
    input  logic [NUM_UNITS-1:0]          unit_done,
    output logic [NUM_UNITS-1:0]          clear_set,
    output logic                          writer_start,
    output logic [$clog2(NUM_UNITS):0]    writer_unit,
    input  logic                          writer_busy,
    input  logic                          writer_flushed,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_used,
    output logic                          busy,
    output logic                          err
);
    localparam int SEL_W = $clog2(NUM_UNITS) + 1;
    localparam int FW    = CMD_ADDR_W + DATA_W;
    localparam logic [NUM_UNITS-1:0] ALL_UNITS = '1;

    logic [FW-1:0]         head_s;
    logic [CMD_ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0]     head_data_s;
    logic                  fifo_full_s, fifo_empty_s, push_s, pop_s;
    logic [NUM_UNITS-1:0]  avail_s, sel_mask_s, launched_q, launched_d;
    logic [SEL_W-1:0]      sel_q, sel_d, next_sel_s;
    logic [7:0]            sel_idx_s;
    logic                  auto_q, auto_d, bcast_q, bcast_d, err_q, err_d;
    logic [NUM_UNITS-1:0]  reg_we_q, reg_we_d, unit_start_q, unit_start_d;
    logic [NUM_UNITS-1:0]  clear_set_q, clear_set_d;
    logic [CMD_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]     reg_data_q, reg_data_d;
    logic                  writer_start_q, writer_start_d;
    logic [SEL_W-1:0]      writer_unit_q, writer_unit_d;

    function automatic logic [NUM_UNITS-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NUM_UNITS'(1) << idx;
    endfunction

    assign cmd_ready = ~fifo_full_s;
    assign push_s    = cmd_valid & ~fifo_full_s;

    sync_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
        .clk   (gpu_clk),
        .rst   (gpu_rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({cmd_addr, cmd_data}),
        .rdata (head_s),
        .count (fifo_used),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_addr_s = head_s[FW-1:DATA_W];
    assign head_data_s = head_s[DATA_W-1:0];
    assign sel_idx_s   = head_data_s[SEL_MSB:SEL_LSB];
    assign sel_mask_s  = onehot(sel_q);
    assign next_sel_s  = (sel_q == SEL_W'(NUM_UNITS - 1)) ? '0 : sel_q + SEL_W'(1);
    // A unit still marked launched is not available even if done is stale-high.
    assign avail_s     = unit_done & ~launched_q;

    // Head decode: decide the pop and the strobes registered at the next edge.
    always_comb begin
        pop_s          = 1'b0;
        reg_we_d       = '0;
        reg_addr_d     = reg_addr_q;
        reg_data_d     = reg_data_q;
        unit_start_d   = '0;
        clear_set_d    = '0;
        writer_start_d = 1'b0;
        writer_unit_d  = writer_unit_q;
        sel_d          = sel_q;
        auto_d         = auto_q;
        bcast_d        = bcast_q;
        err_d          = err_q;
        if (fifo_empty_s) begin
            pop_s = 1'b0;
        end else if (head_addr_s != CMD_ADDR_W'(CTRL_ADDR)) begin
            pop_s      = 1'b1;
            reg_we_d   = bcast_q ? ALL_UNITS : sel_mask_s;
            reg_addr_d = head_addr_s;
            reg_data_d = head_data_s;
        end else begin
            case (head_data_s[3:0])
                OP_START_RASTER: begin
                    if (|(avail_s & sel_mask_s)) begin
                        pop_s        = 1'b1;
                        unit_start_d = sel_mask_s;
                        sel_d        = auto_q ? next_sel_s : sel_q;
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                OP_START_WRITE: begin
                    if ((|(avail_s & sel_mask_s)) && !writer_busy) begin
                        pop_s          = 1'b1;
                        writer_start_d = 1'b1;
                        writer_unit_d  = sel_q;
                        clear_set_d    = sel_mask_s;
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                OP_WAIT_FLUSH: pop_s = writer_flushed;
                OP_CLEAR: begin
                    pop_s       = 1'b1;
                    clear_set_d = bcast_q ? ALL_UNITS : sel_mask_s;
                end
                OP_SELECT: begin
                    pop_s = 1'b1;
                    if (sel_idx_s < 8'(NUM_UNITS)) begin
                        sel_d = SEL_W'(sel_idx_s);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_FENCE: pop_s = (&avail_s) & ~writer_busy;
                OP_MODE: begin
                    pop_s   = 1'b1;
                    auto_d  = head_data_s[MODE_AUTO_BIT];
                    bcast_d = head_data_s[MODE_BCAST_BIT];
                end
                default: pop_s = 1'b1;
            endcase
        end
    end

    // Launch lockout: set with the start strobe, cleared once done is seen low.
    always_comb begin
        launched_d = launched_q;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_start_d[u]) begin
                launched_d[u] = 1'b1;
            end else if (!unit_done[u]) begin
                launched_d[u] = 1'b0;
            end else begin
                launched_d[u] = launched_q[u];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge gpu_clk or posedge gpu_rst) begin
        if (gpu_rst) begin
            launched_q     <= '0;
            sel_q          <= '0;
            auto_q         <= 1'b0;
            bcast_q        <= 1'b0;
            err_q          <= 1'b0;
            reg_we_q       <= '0;
            reg_addr_q     <= '0;
            reg_data_q     <= '0;
            unit_start_q   <= '0;
            clear_set_q    <= '0;
            writer_start_q <= 1'b0;
            writer_unit_q  <= '0;
        end else begin
            launched_q     <= launched_d;
            sel_q          <= sel_d;
            auto_q         <= auto_d;
            bcast_q        <= bcast_d;
            err_q          <= err_d;
            reg_we_q       <= reg_we_d;
            reg_addr_q     <= reg_addr_d;
            reg_data_q     <= reg_data_d;
            unit_start_q   <= unit_start_d;
            clear_set_q    <= clear_set_d;
            writer_start_q <= writer_start_d;
            writer_unit_q  <= writer_unit_d;
        end
    end

    assign reg_we       = reg_we_q;
    assign reg_addr     = reg_addr_q;
    assign reg_data     = reg_data_q;
    assign unit_start   = unit_start_q;
    assign clear_set    = clear_set_q;
    assign writer_start = writer_start_q;
    assign writer_unit  = writer_unit_q;
    assign err          = err_q;
    assign busy         = (fifo_used != '0) | (|launched_q);

endmodule
